// File: rtl/ram_arb_pkg.sv
// Shared constants for the RAM arbiter: default parameters, FSM encoding and
// an index-width helper used by the top and the priority picker.
package ram_arb_pkg;

  localparam int unsigned RA_NUM_PORT       = 4;
  localparam int unsigned RA_SRAM_WIDTH     = 128;
  localparam int unsigned RA_SRAM_DEPTH_BIT = 6;

  // Two-state arbiter FSM encoding
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  // Port-index width; never below one bit so single-port builds still elaborate
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_arb_rr_pick.sv
// Cyclic priority picker: selects the first asserted request at or after ptr,
// wrapping around the port vector.
//   req   : request vector, one bit per port
//   ptr   : search start position
//   grant : one-hot winner (all zero when no request)
//   idx   : binary index of the winner (zero when no request)
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter int unsigned N  = RA_NUM_PORT,
  parameter int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  int unsigned pos;
  logic        found;

  // Walk offsets 0..N-1 from ptr; the first hit wins
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= N) pos = pos - N;
      if (!found && req[IW'(pos)]) begin
        found             = 1'b1;
        grant[IW'(pos)]   = 1'b1;
        idx               = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/ram_arb.sv
// Burst-aware round-robin arbiter sharing one single-port RAM bank among
// NUM_PORT requesters.
//   clk, rst_n      : clock, synchronous active-low reset
//   req_vld/wr/last : per-port beat valid, direction (1=write), burst end
//   req_addr/wdata  : packed per-port address and write data (port i = slice i)
//   req_rdy         : one-hot grant, combinational from registered state
//   rd_vld/id/data  : read return, one cycle after the accepted read
//   ram_*           : RAM strobes, addresses and data
module ram_arb
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_PORT       = RA_NUM_PORT,
  parameter int unsigned SRAM_WIDTH     = RA_SRAM_WIDTH,
  parameter int unsigned SRAM_DEPTH_BIT = RA_SRAM_DEPTH_BIT,
  localparam int unsigned IW            = idx_width(NUM_PORT)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORT-1:0]              req_vld,
  input  logic [NUM_PORT-1:0]              req_wr,
  input  logic [NUM_PORT-1:0]              req_last,
  input  logic [NUM_PORT*SRAM_DEPTH_BIT-1:0] req_addr,
  input  logic [NUM_PORT*SRAM_WIDTH-1:0]   req_wdata,
  output logic [NUM_PORT-1:0]              req_rdy,
  output logic                             rd_vld,
  output logic [IW-1:0]                    rd_id,
  output logic [SRAM_WIDTH-1:0]            rd_data,
  output logic                             ram_read_en,
  output logic                             ram_write_en,
  output logic [SRAM_DEPTH_BIT-1:0]        ram_addr_r,
  output logic [SRAM_DEPTH_BIT-1:0]        ram_addr_w,
  output logic [SRAM_WIDTH-1:0]            ram_data_in,
  input  logic [SRAM_WIDTH-1:0]            ram_data_out
);

  localparam int unsigned AW = SRAM_DEPTH_BIT;
  localparam int unsigned DW = SRAM_WIDTH;

  logic [0:0]          state_q, state_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [IW-1:0]       ptr_q,   ptr_d;
  logic                rd_vld_q;
  logic [IW-1:0]       rd_id_q;

  logic [NUM_PORT-1:0] pick_oh;
  logic [IW-1:0]       pick_idx;
  logic [NUM_PORT-1:0] gnt_oh;
  logic [IW-1:0]       gnt_idx;
  logic                accept;
  logic                acc_wr;
  logic                acc_last;
  logic [AW-1:0]       sel_addr;
  logic [DW-1:0]       sel_wdata;

  rr_pick #(
    .N  (NUM_PORT),
    .IW (IW)
  ) u_pick (
    .req   (req_vld),
    .ptr   (ptr_q),
    .grant (pick_oh),
    .idx   (pick_idx)
  );

  // Grant: owner is locked in during a burst, otherwise the cyclic pick
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    if (rst_n) begin
      if (state_q == ST_BURST) begin
        gnt_oh[owner_q] = 1'b1;
        gnt_idx         = owner_q;
      end else begin
        gnt_oh  = pick_oh;
        gnt_idx = pick_idx;
      end
    end
  end

  // Mux the granted port's beat fields
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    acc_wr    = 1'b0;
    acc_last  = 1'b0;
    for (int unsigned i = 0; i < NUM_PORT; i++) begin
      if (gnt_idx == IW'(i)) begin
        sel_addr  = req_addr[i*AW +: AW];
        sel_wdata = req_wdata[i*DW +: DW];
        acc_wr    = req_wr[i];
        acc_last  = req_last[i];
      end
    end
  end

  assign accept = |(req_vld & gnt_oh);

  // Next-state: open a burst on a non-last beat, close it and advance the
  // pointer past the granted port on any last beat
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (accept) begin
      if (acc_last) begin
        state_d = ST_IDLE;
        ptr_d   = (gnt_idx == IW'(NUM_PORT - 1)) ? '0 : gnt_idx + IW'(1);
      end else begin
        state_d = ST_BURST;
        owner_d = gnt_idx;
      end
    end
  end

  // State register; reset abandons any burst and drops the pending return
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      ptr_q    <= '0;
      rd_vld_q <= 1'b0;
      rd_id_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      rd_vld_q <= accept & ~acc_wr;
      if (accept & ~acc_wr) rd_id_q <= gnt_idx;
    end
  end

  assign req_rdy      = gnt_oh;
  assign ram_write_en = accept & acc_wr;
  assign ram_read_en  = accept & ~acc_wr;
  assign ram_addr_w   = sel_addr;
  assign ram_addr_r   = sel_addr;
  assign ram_data_in  = sel_wdata;
  assign rd_vld       = rd_vld_q;
  assign rd_id        = rd_id_q;
  // RAM output is already aligned with rd_vld (one-cycle read latency)
  assign rd_data      = ram_data_out;

endmodule

// File: tb/tb_ram_arb.sv
module tb_ram_arb;

  localparam int N  = 4;
  localparam int AW = 6;
  localparam int DW = 128;
  localparam int DEPTH = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_vld = '0;
  logic [N-1:0]      req_wr = '0;
  logic [N-1:0]      req_last = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*DW-1:0]   req_wdata = '0;
  logic [N-1:0]      req_rdy;
  logic              rd_vld;
  logic [1:0]        rd_id;
  logic [DW-1:0]     rd_data;
  logic              ram_read_en, ram_write_en;
  logic [AW-1:0]     ram_addr_r, ram_addr_w;
  logic [DW-1:0]     ram_data_in;
  logic [DW-1:0]     ram_data_out = '0;

  int errors = 0;
  int checks = 0;

  ram_arb dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_wr(req_wr), .req_last(req_last),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rdy(req_rdy),
    .rd_vld(rd_vld), .rd_id(rd_id), .rd_data(rd_data),
    .ram_read_en(ram_read_en), .ram_write_en(ram_write_en),
    .ram_addr_r(ram_addr_r), .ram_addr_w(ram_addr_w),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // RAM bank seen by the DUT
  logic [DW-1:0] mem  [DEPTH];
  // Reference contents kept by the model
  logic [DW-1:0] gold [DEPTH];

  always @(posedge clk) begin
    if (ram_write_en) mem[ram_addr_w] <= ram_data_in;
    if (ram_read_en)  ram_data_out <= mem[ram_addr_r];
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_port(input int p, input bit v, input bit w, input bit l,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_vld[p]          = v;
    req_wr[p]           = w;
    req_last[p]         = l;
    req_addr[p*AW +: AW] = a;
    req_wdata[p*DW +: DW] = d;
  endtask

  task automatic clear_all();
    for (int p = 0; p < N; p++) set_port(p, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: owner (-1 = none), round-robin start, pending read
  int            m_owner = -1;
  int            m_ptr = 0;
  bit            m_pend = 1'b0;
  int            m_rd_id = 0;
  logic [DW-1:0] m_rd_data = '0;
  logic [N-1:0]  exp_rdy;
  int            g;
  int            pp;
  bit            acc, exp_we, exp_re;
  logic [AW-1:0] g_addr;

  // Compare process: outputs are stable at the falling edge
  always @(negedge clk) begin
    exp_rdy = '0;
    g = -1;
    if (rst_n) begin
      if (m_owner >= 0) begin
        g = m_owner;
        exp_rdy[g] = 1'b1;
      end else begin
        for (int k = 0; k < N; k++) begin
          pp = (m_ptr + k) % N;
          if (g < 0 && req_vld[pp]) begin
            g = pp;
            exp_rdy[pp] = 1'b1;
          end
        end
      end
    end
    acc = 1'b0;
    if (g >= 0) acc = req_vld[g];
    exp_we = acc && req_wr[g >= 0 ? g : 0];
    exp_re = acc && !req_wr[g >= 0 ? g : 0];
    g_addr = (g >= 0) ? req_addr[(g >= 0 ? g : 0)*AW +: AW] : '0;

    chk("req_rdy", DW'(req_rdy), DW'(exp_rdy));
    chk("ram_write_en", DW'(ram_write_en), DW'(exp_we));
    chk("ram_read_en", DW'(ram_read_en), DW'(exp_re));
    chk("en_exclusive", DW'(ram_read_en & ram_write_en), '0);
    if (exp_we) begin
      chk("ram_addr_w", DW'(ram_addr_w), DW'(g_addr));
      chk("ram_data_in", ram_data_in, req_wdata[g*DW +: DW]);
    end
    if (exp_re) chk("ram_addr_r", DW'(ram_addr_r), DW'(g_addr));
    chk("rd_vld", DW'(rd_vld), DW'(m_pend));
    if (m_pend) begin
      chk("rd_id", DW'(rd_id), DW'(m_rd_id));
      chk("rd_data", rd_data, m_rd_data);
    end

    // Advance model to the state after the coming rising edge
    if (!rst_n) begin
      m_owner = -1;
      m_ptr   = 0;
      m_pend  = 1'b0;
    end else begin
      m_pend = exp_re;
      if (exp_re) begin
        m_rd_id   = g;
        m_rd_data = gold[g_addr];
      end
      if (exp_we) gold[g_addr] = req_wdata[g*DW +: DW];
      if (acc) begin
        if (req_last[g]) begin
          m_owner = -1;
          m_ptr   = (g + 1) % N;
        end else begin
          m_owner = g;
        end
      end
    end
  end

  int            left [N];
  logic [N-1:0]  acc_vec;
  bit            was_rst;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]  = '0;
      gold[i] = '0;
    end
    for (int p = 0; p < N; p++) left[p] = 0;

    // Reset: requests present but nothing may be granted
    set_port(0, 1'b1, 1'b0, 1'b1, 6'd3, '0);
    repeat (3) next_cycle();
    chk("reset_rdy", DW'(req_rdy), '0);
    chk("reset_re", DW'(ram_read_en), '0);
    chk("reset_we", DW'(ram_write_en), '0);
    chk("reset_rd_vld", DW'(rd_vld), '0);
    chk("reset_rd_id", DW'(rd_id), '0);

    // Ports 0 and 2 single reads: 0 first, then 2, returns back-to-back
    clear_all();
    set_port(0, 1'b1, 1'b0, 1'b1, 6'd1, '0);
    set_port(2, 1'b1, 1'b0, 1'b1, 6'd2, '0);
    rst_n = 1'b1;
    #1 chk("t1_grant0", DW'(req_rdy), DW'(4'b0001));
    next_cycle();
    set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
    #1 chk("t1_grant2", DW'(req_rdy), DW'(4'b0100));
    chk("t1_rd_vld0", DW'(rd_vld), 1);
    chk("t1_rd_id0", DW'(rd_id), 0);
    next_cycle();
    clear_all();
    #1 chk("t1_rd_vld2", DW'(rd_vld), 1);
    chk("t1_rd_id2", DW'(rd_id), 2);

    // Write 0xA5 to addr 5 then read it back the next cycle
    next_cycle();
    set_port(3, 1'b1, 1'b1, 1'b1, 6'd5, DW'(8'hA5));
    #1 chk("t3_we", DW'(ram_write_en), 1);
    chk("t3_addr_w", DW'(ram_addr_w), 5);
    chk("t3_data_in", ram_data_in, DW'(8'hA5));
    next_cycle();
    clear_all();
    set_port(0, 1'b1, 1'b0, 1'b1, 6'd5, '0);
    #1 chk("t3_re", DW'(ram_read_en), 1);
    chk("t3_addr_r", DW'(ram_addr_r), 5);
    next_cycle();
    clear_all();
    #1 chk("t3_rd_vld", DW'(rd_vld), 1);
    chk("t3_rd_data", rd_data, DW'(8'hA5));

    // Port 1 four-beat write burst holds off port 3
    next_cycle();
    set_port(3, 1'b1, 1'b0, 1'b1, 6'd0, '0);
    for (int b = 0; b < 4; b++) begin
      set_port(1, 1'b1, 1'b1, b == 3, AW'(8 + b), DW'(32'h100 + b));
      #1 chk("t2_hold_p3", DW'(req_rdy), DW'(4'b0010));
      chk("t2_addr_w", DW'(ram_addr_w), DW'(8 + b));
      next_cycle();
    end
    set_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
    #1 chk("t2_grant3", DW'(req_rdy), DW'(4'b1000));
    next_cycle();
    clear_all();

    // All four ports request single beats: strict rotation
    next_cycle();
    for (int p = 0; p < N; p++) set_port(p, 1'b1, 1'b0, 1'b1, AW'(p), '0);
    for (int c = 0; c < 8; c++) begin
      #1 chk("t4_rotation", DW'(req_rdy), DW'(1 << (c % 4)));
      next_cycle();
    end
    clear_all();
    next_cycle();

    // Reset on beat 2 of a port-0 read burst
    set_port(0, 1'b1, 1'b0, 1'b0, 6'd20, '0);
    #1 chk("t5_beat1", DW'(req_rdy), DW'(4'b0001));
    next_cycle();
    set_port(0, 1'b1, 1'b0, 1'b0, 6'd21, '0);
    rst_n = 1'b0;
    #1 chk("t5_rst_rdy", DW'(req_rdy), '0);
    next_cycle();
    #1 chk("t5_no_rd_vld", DW'(rd_vld), '0);
    rst_n = 1'b1;
    clear_all();
    set_port(3, 1'b1, 1'b0, 1'b1, 6'd7, '0);
    #1 chk("t5_grant3", DW'(req_rdy), DW'(4'b1000));
    next_cycle();
    clear_all();
    #1 chk("t5_rd_id3", DW'(rd_id), 3);

    // Randomized traffic: bursts of 1..4 beats, mixed directions, gaps, resets
    was_rst = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      #2;
      acc_vec = req_vld & req_rdy;
      next_cycle();
      if (was_rst) begin
        clear_all();
        for (int p = 0; p < N; p++) left[p] = 0;
        acc_vec = '0;
      end
      for (int p = 0; p < N; p++) begin
        if (acc_vec[p]) begin
          left[p]--;
          req_vld[p] = 1'b0;
        end
        if (left[p] == 0 && !req_vld[p] && $urandom_range(0, 3) == 0)
          left[p] = $urandom_range(1, 4);
        if (left[p] > 0 && !req_vld[p] && $urandom_range(0, 7) != 0)
          set_port(p, 1'b1, $urandom_range(0, 1) == 1, left[p] == 1,
                   AW'($urandom_range(0, 15)),
                   {$urandom, $urandom, $urandom, $urandom});
      end
      rst_n   = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      was_rst = !rst_n;
    end

    rst_n = 1'b1;
    clear_all();
    repeat (3) next_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
